// File: rtl/hex_display_sequencer.sv
// Shares the GPIO bus between the CPU and a sequencer that writes a 32-bit value
// as eight active-low 7-segment codes to HEX0..HEX7; CPU cycles always win the bus.
module hex_display_sequencer #(
    parameter logic [11:0] BASE_ADDR     = 12'h010,
    parameter bit          LEADING_BLANK = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_cs_n,
    input  logic        cpu_rd_n,
    input  logic        cpu_wr_n,
    input  logic [11:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic        start,
    input  logic [31:0] value,
    output logic        busy,
    output logic        done,
    output logic        gpio_cs_n,
    output logic        gpio_rd_n,
    output logic        gpio_wr_n,
    output logic [11:0] gpio_addr,
    output logic [31:0] gpio_wdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [31:0] val_q, val_d;
    logic        busy_q, done_q;

    logic        cpu_act;
    logic        seq_wr;
    logic [2:0]  msn;
    logic [3:0]  nib;
    logic [6:0]  seg_code;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'h40;
            4'h1: seg7 = 7'h79;
            4'h2: seg7 = 7'h24;
            4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;
            4'h5: seg7 = 7'h12;
            4'h6: seg7 = 7'h02;
            4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;
            4'h9: seg7 = 7'h10;
            4'hA: seg7 = 7'h08;
            4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;
            4'hD: seg7 = 7'h21;
            4'hE: seg7 = 7'h06;
            default: seg7 = 7'h0E;
        endcase
    endfunction

    assign cpu_act = ~cpu_cs_n & (~cpu_rd_n | ~cpu_wr_n);

    // Highest nonzero nibble; a zero value keeps HEX0 lit so the display shows "0".
    always_comb begin
        msn = '0;
        for (int unsigned i = 1; i < 8; i++) begin
            if (val_q[4*i +: 4] != 4'h0) msn = 3'(i);
        end
    end

    assign nib      = val_q[{idx_q, 2'b00} +: 4];
    assign seg_code = (LEADING_BLANK && (idx_q > msn)) ? 7'h7F : seg7(nib);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        val_d   = val_q;
        seq_wr  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    val_d   = value;
                    idx_d   = '0;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (!cpu_act) begin
                    seq_wr = 1'b1;
                    if (idx_q == 3'd7) state_d = DONE;
                    else               idx_d   = idx_q + 3'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Reset gates the sequencer off the bus in the same cycle it is asserted.
    always_comb begin
        gpio_cs_n  = cpu_cs_n;
        gpio_rd_n  = cpu_rd_n;
        gpio_wr_n  = cpu_wr_n;
        gpio_addr  = cpu_addr;
        gpio_wdata = cpu_wdata;
        if (seq_wr && !reset) begin
            gpio_cs_n  = 1'b0;
            gpio_rd_n  = 1'b1;
            gpio_wr_n  = 1'b0;
            gpio_addr  = BASE_ADDR + {7'b0, idx_q, 2'b00};
            gpio_wdata = {25'b0, seg_code};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            val_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            val_q   <= val_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == DONE);
        end
    end

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_hex_display_sequencer.sv
// Directed bench for hex_display_sequencer: one instance without and one with leading blanking.
module tb_hex_display_sequencer;

    logic        clk;
    logic        reset;
    logic        cpu_cs_n, cpu_rd_n, cpu_wr_n;
    logic [11:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        start;
    logic [31:0] value;

    logic        busy0, done0, g0_cs_n, g0_rd_n, g0_wr_n;
    logic [11:0] g0_addr;
    logic [31:0] g0_wdata;
    logic        busy1, done1, g1_cs_n, g1_rd_n, g1_wr_n;
    logic [11:0] g1_addr;
    logic [31:0] g1_wdata;

    int checks   = 0;
    int failures = 0;

    hex_display_sequencer #(.BASE_ADDR(12'h010), .LEADING_BLANK(1'b0)) dut0 (
        .clk(clk), .reset(reset),
        .cpu_cs_n(cpu_cs_n), .cpu_rd_n(cpu_rd_n), .cpu_wr_n(cpu_wr_n),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .start(start), .value(value), .busy(busy0), .done(done0),
        .gpio_cs_n(g0_cs_n), .gpio_rd_n(g0_rd_n), .gpio_wr_n(g0_wr_n),
        .gpio_addr(g0_addr), .gpio_wdata(g0_wdata)
    );

    hex_display_sequencer #(.BASE_ADDR(12'h010), .LEADING_BLANK(1'b1)) dut1 (
        .clk(clk), .reset(reset),
        .cpu_cs_n(cpu_cs_n), .cpu_rd_n(cpu_rd_n), .cpu_wr_n(cpu_wr_n),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .start(start), .value(value), .busy(busy1), .done(done1),
        .gpio_cs_n(g1_cs_n), .gpio_rd_n(g1_rd_n), .gpio_wr_n(g1_wr_n),
        .gpio_addr(g1_addr), .gpio_wdata(g1_wdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0]       value;
        logic [0:7][6:0]   e0;
        logic [0:7][6:0]   e1;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [46:0] wr_exp(input int i, input logic [6:0] d);
        return {1'b0, 1'b1, 1'b0, 12'h010 + 12'(4 * i), 25'b0, d};
    endfunction

    function automatic logic [46:0] pt_exp();
        return {cpu_cs_n, cpu_rd_n, cpu_wr_n, cpu_addr, cpu_wdata};
    endfunction

    task automatic check_bus(input string nm, input logic [46:0] e0, input logic [46:0] e1);
        chk({nm, "_lb0"}, 64'({g0_cs_n, g0_rd_n, g0_wr_n, g0_addr, g0_wdata}), 64'(e0));
        chk({nm, "_lb1"}, 64'({g1_cs_n, g1_rd_n, g1_wr_n, g1_addr, g1_wdata}), 64'(e1));
    endtask

    // Expected {busy0, busy1, done0, done1}.
    task automatic check_flags(input string nm, input logic [3:0] e);
        chk(nm, 64'({busy0, busy1, done0, done1}), 64'(e));
    endtask

    task automatic cpu_idle();
        cpu_cs_n  = 1'b1;
        cpu_rd_n  = 1'b1;
        cpu_wr_n  = 1'b1;
        cpu_addr  = 12'h3C0;
        cpu_wdata = 32'hDEAD_BEEF;
    endtask

    logic [0:7][6:0] d89;
    int k;

    initial begin
        vecs[0].value = 32'h89AB_CDEF;
        vecs[0].e0 = {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00};
        vecs[0].e1 = {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00};
        vecs[1].value = 32'h0000_0305;
        vecs[1].e0 = {7'h12, 7'h40, 7'h30, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
        vecs[1].e1 = {7'h12, 7'h40, 7'h30, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
        vecs[2].value = 32'h0000_0000;
        vecs[2].e0 = {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
        vecs[2].e1 = {7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
        vecs[3].value = 32'h1234_5670;
        vecs[3].e0 = {7'h40, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
        vecs[3].e1 = {7'h40, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
        vecs[4].value = 32'h000A_0000;
        vecs[4].e0 = {7'h40, 7'h40, 7'h40, 7'h40, 7'h08, 7'h40, 7'h40, 7'h40};
        vecs[4].e1 = {7'h40, 7'h40, 7'h40, 7'h40, 7'h08, 7'h7F, 7'h7F, 7'h7F};
        d89 = vecs[0].e0;

        // Reset: outputs idle, bus mirrors an active CPU read.
        reset = 1'b1; start = 1'b0; value = '0;
        cpu_idle();
        cpu_cs_n = 1'b0; cpu_rd_n = 1'b0; cpu_addr = 12'h044;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_flags("reset_flags", 4'b0000);
        check_bus("reset_bus", pt_exp(), pt_exp());
        @(posedge clk); #1 reset = 1'b0; cpu_idle();
        @(negedge clk);
        check_bus("idle_bus", pt_exp(), pt_exp());

        // Uncontended sequences; value is scrambled after the start cycle.
        for (int v = 0; v < 5; v++) begin
            @(posedge clk); #1 start = 1'b1; value = vecs[v].value;
            @(negedge clk);
            check_flags($sformatf("v%0d_start_flags", v), 4'b0000);
            check_bus($sformatf("v%0d_start_bus", v), pt_exp(), pt_exp());
            @(posedge clk); #1 start = 1'b0; value = ~vecs[v].value;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                check_bus($sformatf("v%0d_hex%0d", v, i),
                          wr_exp(i, vecs[v].e0[i]), wr_exp(i, vecs[v].e1[i]));
                check_flags($sformatf("v%0d_w%0d_flags", v, i), 4'b1100);
            end
            @(negedge clk);
            check_flags($sformatf("v%0d_done_flags", v), 4'b1111);
            check_bus($sformatf("v%0d_done_bus", v), pt_exp(), pt_exp());
            @(negedge clk);
            check_flags($sformatf("v%0d_after_flags", v), 4'b0000);
        end

        // CPU write in N+3..N+4 stalls; a select without strobes at N+6 must not stall.
        @(posedge clk); #1 start = 1'b1; value = 32'h89AB_CDEF;
        @(negedge clk);
        k = 0;
        for (int c = 1; c <= 11; c++) begin
            @(posedge clk); #1 start = 1'b0;
            cpu_idle();
            if (c == 3 || c == 4) begin
                cpu_cs_n = 1'b0; cpu_wr_n = 1'b0;
                cpu_addr = 12'h008; cpu_wdata = 32'h1234_5670 + 32'(c);
            end else if (c == 6) begin
                cpu_cs_n = 1'b0; cpu_addr = 12'h008;
            end
            @(negedge clk);
            if (c == 3 || c == 4) begin
                check_bus($sformatf("stall_c%0d_cpu", c), pt_exp(), pt_exp());
                check_flags($sformatf("stall_c%0d_flags", c), 4'b1100);
            end else if (c <= 10) begin
                check_bus($sformatf("stall_c%0d_hex%0d", c, k), wr_exp(k, d89[k]), wr_exp(k, d89[k]));
                check_flags($sformatf("stall_c%0d_flags", c), 4'b1100);
                k++;
            end else begin
                check_bus("stall_done_bus", pt_exp(), pt_exp());
                check_flags("stall_done_flags", 4'b1111);
            end
        end
        @(posedge clk); #1 cpu_idle();
        @(negedge clk);
        check_flags("stall_after_flags", 4'b0000);

        // Second start at N+4 is ignored; reset at N+6 aborts with no further writes or done.
        @(posedge clk); #1 start = 1'b1; value = 32'h89AB_CDEF;
        @(negedge clk);
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1 start = (c == 4); value = (c == 4) ? 32'h0 : 32'h89AB_CDEF;
            @(negedge clk);
            check_bus($sformatf("abort_c%0d_hex%0d", c, c - 1),
                      wr_exp(c - 1, d89[c - 1]), wr_exp(c - 1, d89[c - 1]));
        end
        @(posedge clk); #1 start = 1'b0; reset = 1'b1;
        cpu_cs_n = 1'b0; cpu_rd_n = 1'b0; cpu_addr = 12'h030;
        @(negedge clk);
        check_bus("abort_reset_bus", pt_exp(), pt_exp());
        @(posedge clk); #1;
        @(negedge clk);
        check_bus("abort_reset2_bus", pt_exp(), pt_exp());
        check_flags("abort_reset_flags", 4'b0000);
        @(posedge clk); #1 reset = 1'b0; cpu_idle();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check_bus($sformatf("abort_post%0d_bus", c), pt_exp(), pt_exp());
            check_flags($sformatf("abort_post%0d_flags", c), 4'b0000);
            @(posedge clk); #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
